dac_instr_sched: RTL and testbench

DAC_INSTR_SCHED -- requirements
Module: dac_instr_sched

---
 rtl/dac_instr_sched_pkg.sv | 21 ++
 rtl/dac_instr_sched_fifo.sv | 64 ++++++
 rtl/dac_instr_sched.sv | 151 +++++++++++++++
 tb/tb_dac_instr_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_instr_sched_pkg.sv
// pid_pkg -- shared definitions for the DAC instruction scheduler.
//   Default sizing constants, scheduler FSM encoding and the queued
//   instruction record {chan, data} at the default sizing.
package pid_pkg;

    localparam int W_DATA_DEF = 16;
    localparam int W_CHS_DEF  = 3;
    localparam int N_CHAN_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SCHED = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [W_CHS_DEF-1:0]  chan;
        logic [W_DATA_DEF-1:0] data;
    } instr_t;

endpackage

// File: rtl/dac_instr_sched_fifo.sv
// instr_fifo -- synchronous show-ahead FIFO for scheduled DAC instructions.
//   clk_in, reset_in  : clock / synchronous active-high reset
//   wr_en_i, wr_data_i: push (accepted when not full, or when popping too)
//   rd_en_i           : pop head (ignored when empty)
//   rd_data_o         : head entry (valid while !empty_o)
//   full_o, empty_o   : status
//   count_o           : occupancy, 0..DEPTH
module instr_fifo
    import pid_pkg::*;
#(
    parameter int WIDTH = W_CHS_DEF + W_DATA_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int W_CNT = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [W_CNT-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [W_CNT-1:0] wr_ptr_q, wr_ptr_d;
    logic [W_CNT-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // Pointers carry one extra bit so full and empty are distinguishable;
    // the low AW bits address storage and wrap modulo DEPTH.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == W_CNT'(DEPTH));
    assign empty_o = (count_o == '0);

    assign do_rd = rd_en_i && !empty_o;
    // A write into a full FIFO is fine when the head leaves at the same edge.
    assign do_wr = wr_en_i && (!full_o || do_rd);

    assign wr_ptr_d  = do_wr ? wr_ptr_q + W_CNT'(1) : wr_ptr_q;
    assign rd_ptr_d  = do_rd ? rd_ptr_q + W_CNT'(1) : rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the consumer only looks at it while non-empty.
    always_ff @(posedge clk_in) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/dac_instr_sched.sv
// dac_instr_sched -- coalescing per-channel DAC update scheduler.
//   Each channel strobe latches a word into hold[c] and marks it pending;
//   a round-robin arbiter moves one pending channel per cycle into an
//   instruction FIFO as {chan, data}. Repeated strobes on a still-pending
//   channel collapse into one entry carrying the newest word.
//   clk_in, reset_in : clock / synchronous active-high reset
//   data_packed_in   : channel words, channel c at [W_DATA*c +: W_DATA]
//   data_valid_in    : per-channel update strobe
//   rd_ack_in        : pop FIFO head (ignored when empty)
//   data_out/chan_out: FIFO head (zero while empty)
//   data_valid_out   : FIFO non-empty (show-ahead)
//   count_out        : FIFO occupancy
//   overrun_out      : sticky overwrite flags; only with DAC_SCHED_OVERRUN_EN
//                      defined, otherwise tied to zero.
module dac_instr_sched
    import pid_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEF,
    parameter int W_CHS  = W_CHS_DEF,
    parameter int N_CHAN = N_CHAN_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int W_CNT  = $clog2(DEPTH) + 1
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic [W_DATA*N_CHAN-1:0]   data_packed_in,
    input  logic [N_CHAN-1:0]          data_valid_in,
    input  logic                       rd_ack_in,
    output logic [W_DATA-1:0]          data_out,
    output logic [W_CHS-1:0]           chan_out,
    output logic                       data_valid_out,
    output logic [W_CNT-1:0]           count_out,
    output logic [N_CHAN-1:0]          overrun_out
);

    localparam int W_INSTR = W_CHS + W_DATA;

    logic [N_CHAN-1:0][W_DATA-1:0] hold_q, hold_d;
    logic [N_CHAN-1:0]             pend_q, pend_d;
    logic [W_CHS-1:0]              rr_q, rr_d;
    sched_state_e                  state_q, state_d;

    logic [W_CHS-1:0]   gnt_idx;
    logic               gnt_vld;
    logic               grant;
    logic [N_CHAN-1:0]  gnt_oh;
    logic               wr_ok;

    logic [W_INSTR-1:0] fifo_wdata, fifo_head;
    logic               fifo_full, fifo_empty;
    logic [W_CNT-1:0]   fifo_count;

    // Round-robin search: first pending channel strictly after rr_q.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 1; i <= N_CHAN; i++) begin
            int idx;
            idx = int'(rr_q) + i;
            if (idx >= N_CHAN) idx = idx - N_CHAN;
            if (!gnt_vld && pend_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = W_CHS'(idx);
            end
        end
    end

    assign wr_ok = !fifo_full || (rd_ack_in && !fifo_empty);
    assign grant = (state_q == ST_SCHED) && gnt_vld && wr_ok;

    // A strobe in the grant cycle wins over the clear: the old word is
    // enqueued and the new one stays pending.
    always_comb begin
        gnt_oh = '0;
        if (grant) gnt_oh[gnt_idx] = 1'b1;
        for (int c = 0; c < N_CHAN; c++) begin
            hold_d[c] = data_valid_in[c] ? data_packed_in[W_DATA*c +: W_DATA] : hold_q[c];
            pend_d[c] = data_valid_in[c] | (pend_q[c] & ~gnt_oh[c]);
        end
        rr_d = grant ? gnt_idx : rr_q;
    end

    assign fifo_wdata = {gnt_idx, hold_q[gnt_idx]};

    // Scheduler FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|pend_q || |data_valid_in) state_d = ST_SCHED;
            ST_SCHED: if (pend_d == '0 && data_valid_in == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Scheduler FSM: state register
    always_ff @(posedge clk_in) begin
        if (reset_in) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Reset priority also discards strobes present in the reset cycle.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            hold_q <= '0;
            pend_q <= '0;
            rr_q   <= W_CHS'(N_CHAN - 1);
        end else begin
            hold_q <= hold_d;
            pend_q <= pend_d;
            rr_q   <= rr_d;
        end
    end

    instr_fifo #(
        .WIDTH (W_INSTR),
        .DEPTH (DEPTH),
        .W_CNT (W_CNT)
    ) u_fifo (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .wr_en_i   (grant),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (rd_ack_in),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Head is masked while empty so stale storage never shows on the port.
    assign data_valid_out = !fifo_empty;
    assign data_out       = fifo_empty ? '0 : fifo_head[W_DATA-1:0];
    assign chan_out       = fifo_empty ? '0 : fifo_head[W_INSTR-1:W_DATA];
    assign count_out      = fifo_count;

`ifdef DAC_SCHED_OVERRUN_EN
    // Overrun = strobe lands on a pending channel that is not being granted
    // this cycle (a grant collision loses no data).
    logic [N_CHAN-1:0] ovr_q;

    always_ff @(posedge clk_in) begin
        if (reset_in) ovr_q <= '0;
        else          ovr_q <= ovr_q | (data_valid_in & pend_q & ~gnt_oh);
    end

    assign overrun_out = ovr_q;
`else
    assign overrun_out = '0;
`endif

endmodule

// File: tb/tb_dac_instr_sched.sv
module tb_dac_instr_sched;
    import pid_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] dpk;
    logic [7:0]   dvi;
    logic         ack;
    logic [15:0]  dout;
    logic [2:0]   cout;
    logic         dv;
    logic [2:0]   cnt;
    logic [7:0]   ovr;

    int n_pass = 0;
    int n_tot  = 0;
    instr_t got[$];

`ifdef DAC_SCHED_OVERRUN_EN
    localparam logic [7:0] OVR_COAL  = 8'h80;
    localparam logic [7:0] OVR_BURST = 8'h10;
`else
    localparam logic [7:0] OVR_COAL  = 8'h00;
    localparam logic [7:0] OVR_BURST = 8'h00;
`endif

    always #5 clk = ~clk;

    dac_instr_sched #(
        .W_DATA(16), .W_CHS(3), .N_CHAN(8), .DEPTH(4), .W_CNT(3)
    ) dut (
        .clk_in         (clk),
        .reset_in       (rst),
        .data_packed_in (dpk),
        .data_valid_in  (dvi),
        .rd_ack_in      (ack),
        .data_out       (dout),
        .chan_out       (cout),
        .data_valid_out (dv),
        .count_out      (cnt),
        .overrun_out    (ovr)
    );

    typedef struct {
        logic         rst;
        logic [7:0]   vld;
        logic [127:0] words;
        logic         ack;
        logic         v;
        logic [2:0]   ch;
        logic [15:0]  d;
        logic [2:0]   cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [7:0] vl, logic [127:0] w, logic a,
                                logic v, logic [2:0] ch, logic [15:0] d, logic [2:0] c);
        vec_t t;
        t.rst = r; t.vld = vl; t.words = w; t.ack = a;
        t.v = v; t.ch = ch; t.d = d; t.cnt = c;
        return t;
    endfunction

    function automatic logic [127:0] seq_words(logic [15:0] base);
        logic [127:0] w;
        for (int c = 0; c < 8; c++) w[16*c +: 16] = base + 16'(c);
        return w;
    endfunction

    function automatic logic [127:0] one_word(int ch, logic [15:0] val);
        logic [127:0] w;
        w = '0;
        w[16*ch +: 16] = val;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; dvi = '0; ack = 1'b0; dpk = '0;
        tick();
        rst = 1'b0;
    endtask

    // Pops while valid, recording each head before it leaves.
    task automatic drain(input int max);
        got.delete();
        dvi = '0;
        for (int k = 0; k < max && dv; k++) begin
            got.push_back({cout, dout});
            ack = 1'b1;
            tick();
        end
        ack = 1'b0;
        chk("drain_empty", {63'd0, dv}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; dvi = '0; ack = 1'b0; dpk = '0;

        // rst, vld, words, ack  ->  v, ch, d, cnt (after the edge)
        tbl.push_back(mk(1, 8'h00, '0, 0,                     0, 0, 16'h0000, 0)); // reset state
        tbl.push_back(mk(0, 8'h04, one_word(2, 16'hABCD), 0,  0, 0, 16'h0000, 0)); // strobe ch2
        tbl.push_back(mk(0, 8'h00, '0, 0,                     1, 2, 16'hABCD, 1)); // 2 cycles later
        tbl.push_back(mk(0, 8'h00, '0, 1,                     0, 0, 16'h0000, 0)); // pop
        tbl.push_back(mk(0, 8'h00, '0, 1,                     0, 0, 16'h0000, 0)); // ack on empty
        tbl.push_back(mk(1, 8'hFF, seq_words(16'h5000), 0,    0, 0, 16'h0000, 0)); // strobes in reset
        tbl.push_back(mk(0, 8'h00, '0, 0,                     0, 0, 16'h0000, 0)); // were ignored
        tbl.push_back(mk(0, 8'hFF, seq_words(16'h1000), 0,    0, 0, 16'h0000, 0)); // all channels
        tbl.push_back(mk(0, 8'h00, '0, 0,                     1, 0, 16'h1000, 1));
        tbl.push_back(mk(0, 8'h00, '0, 0,                     1, 0, 16'h1000, 2));
        tbl.push_back(mk(0, 8'h00, '0, 0,                     1, 0, 16'h1000, 3));
        tbl.push_back(mk(0, 8'h00, '0, 0,                     1, 0, 16'h1000, 4)); // full
        tbl.push_back(mk(0, 8'h00, '0, 0,                     1, 0, 16'h1000, 4)); // stays full
        tbl.push_back(mk(0, 8'h00, '0, 1,                     1, 1, 16'h1001, 4)); // pop+write
        tbl.push_back(mk(0, 8'h00, '0, 1,                     1, 2, 16'h1002, 4));
        tbl.push_back(mk(0, 8'h00, '0, 1,                     1, 3, 16'h1003, 4));
        tbl.push_back(mk(0, 8'h00, '0, 1,                     1, 4, 16'h1004, 4));
        tbl.push_back(mk(0, 8'h00, '0, 1,                     1, 5, 16'h1005, 3));
        tbl.push_back(mk(0, 8'h00, '0, 1,                     1, 6, 16'h1006, 2));
        tbl.push_back(mk(0, 8'h00, '0, 1,                     1, 7, 16'h1007, 1));
        tbl.push_back(mk(0, 8'h00, '0, 1,                     0, 0, 16'h0000, 0)); // drained

        tick();
        foreach (tbl[i]) begin
            rst = tbl[i].rst; dvi = tbl[i].vld; dpk = tbl[i].words; ack = tbl[i].ack;
            tick();
            chk($sformatf("vec%0d", i), {33'd0, dv, cout, dout, cnt, ovr},
                {33'd0, tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].cnt, 8'h00});
        end
        rst = 1'b0; dvi = '0; ack = 1'b0;

        // Coalescing with the FIFO saturated
        do_reset();
        dvi = 8'hFF; dpk = seq_words(16'h2000);
        tick();
        dvi = '0;
        repeat (4) tick();
        chk("coal_full", {61'd0, cnt}, 64'd4);
        dvi = 8'h80; dpk = one_word(7, 16'hBEEF);
        tick();
        dvi = '0;
        repeat (2) tick();
        chk("coal_sat", {61'd0, cnt}, 64'd4);
        chk("coal_ovr", {56'd0, ovr}, {56'd0, OVR_COAL});
        drain(30);
        chk("coal_n", 64'(got.size()), 64'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            instr_t e;
            e.chan = 3'(i);
            e.data = (i == 7) ? 16'hBEEF : 16'h2000 + 16'(i);
            chk($sformatf("coal_e%0d", i), {45'd0, got[i]}, {45'd0, e});
        end
        chk("coal_cnt0", {61'd0, cnt}, 64'd0);

        // Grant / strobe collision on channel 3
        do_reset();
        dvi = 8'h08; dpk = one_word(3, 16'h0001);
        tick();
        dvi = 8'h08; dpk = one_word(3, 16'h0002);
        tick();
        dvi = '0;
        repeat (2) tick();
        chk("coll_cnt", {61'd0, cnt}, 64'd2);
        chk("coll_ovr", {56'd0, ovr}, 64'd0);
        drain(10);
        chk("coll_n", 64'(got.size()), 64'd2);
        if (got.size() >= 2) begin
            chk("coll_e0", {45'd0, got[0]}, {45'd0, 3'd3, 16'h0001});
            chk("coll_e1", {45'd0, got[1]}, {45'd0, 3'd3, 16'h0002});
        end

        // Reset mid-burst: 3 queued, channels 3 and 4 pending
        do_reset();
        dvi = 8'h1F; dpk = seq_words(16'h3000);
        tick();
        dvi = '0;
        repeat (2) tick();
        dvi = 8'h10; dpk = one_word(4, 16'h3AAA);
        tick();
        dvi = '0;
        chk("burst_cnt", {61'd0, cnt}, 64'd3);
        chk("burst_ovr", {56'd0, ovr}, {56'd0, OVR_BURST});
        rst = 1'b1; dvi = 8'hFF; dpk = seq_words(16'h4000);
        tick();
        rst = 1'b0; dvi = '0;
        chk("burst_rst", {33'd0, dv, cout, dout, cnt, ovr}, 64'd0);
        repeat (5) tick();
        chk("burst_stale", {60'd0, dv, cnt}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
